// File: rtl/arb_mux8way.sv
// arb_mux8way: 8-source valid/ready merge onto one registered, source-tagged output.
// Define ARB_MUX8WAY_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module arb_mux8way #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  output logic [7:0]         in_ready,
  input  logic [8*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } st_t;

  st_t        st;
  st_t        st_nx;
  logic       load_ok;
  logic       gnt_any;
  logic       in_fire;
  logic [2:0] gnt_idx;

  function automatic logic [2:0] lsb_idx(
    input logic [7:0] v
  );
    lsb_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lsb_idx = 3'(i);
    end
  endfunction

`ifdef ARB_MUX8WAY_ROUND_ROBIN_EN
  logic [2:0] ptr;
  logic [7:0] rot;

  // rotate so ptr lands at bit 0; the index sum wraps mod 8
  always_comb begin
    rot     = 8'((in_valid >> ptr) |
                 (in_valid << (4'd8 - {1'b0, ptr})));
    gnt_idx = ptr + lsb_idx(rot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'd0;
    end else if (in_fire) begin
      ptr <= gnt_idx + 3'd1;
    end
  end
`else
  always_comb begin
    gnt_idx = lsb_idx(in_valid);
  end
`endif

  assign out_valid = (st == FULL);
  assign load_ok   = !out_valid | out_ready;
  assign gnt_any   = |in_valid;

  always_comb begin
    in_ready = 8'd0;
    if (load_ok && gnt_any) begin
      in_ready = 8'd1 << gnt_idx;
    end
  end

  assign in_fire = |(in_valid & in_ready);

  always_comb begin
    st_nx = st;
    unique case (st)
      EMPTY: begin
        if (in_fire) st_nx = FULL;
      end
      FULL: begin
        if (out_ready && !in_fire) st_nx = EMPTY;
      end
      default: st_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= EMPTY;
    end else begin
      st <= st_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= 3'd0;
    end else if (in_fire) begin
      out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
      out_sel  <= gnt_idx;
    end
  end

endmodule
